uart_cmd_queue: RTL and testbench
=================================

Name: uart_cmd_queue

Overview:
- Sits between the UART receiver and the game controller.
- Decodes received ASCII key bytes ('1' up, '2' down, '3' left, '4' right, '5' confirm) into 3-bit command codes and buffers them in a small FIFO.
- Releases at most one command per video frame, paced by the vertical-sync edge, so the game controller applies exactly one move per displayed frame.
- Malformed input is counted; FIFO overflow is flagged.

Parameters:
- FIFO_DEPTH, 4, number of buffered commands; power of two, 2..16.
- VS_POL, 1'b0, active level of vs_in; a frame tick occurs on the transition into this level.

Ports:
- clk  input  1  system clock (video pixel clock domain).
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte from the UART receiver.
- rx_data_valid  input  1  one-cycle strobe; rx_data is valid while high.
- vs_in  input  1  vertical sync from the timing generator, same clock domain.
- cmd_code  output  3  command: 1 up, 2 down, 3 left, 4 right, 5 confirm; 0 = none.
- cmd_valid  output  1  one-cycle strobe; cmd_code is newly valid.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of queued commands.
- overflow  output  1  sticky; a command was dropped because the FIFO was full.
- bad_char_cnt  output  8  count of rejected bytes, saturating.

Behaviour:
- Reset (rst high at a clk edge):
  - cmd_code=0, cmd_valid=0, fifo_level=0, overflow=0, bad_char_cnt=0.
  - FIFO pointers are cleared, vs history is cleared to the inactive level, and the decode register is cleared.
  - Reset mid-frame or mid-queue discards all queued commands. The first frame tick after reset needs a genuine inactive-to-active vs transition.
- Decode stage (1 register stage):
  - On rx_data_valid, bytes 0x31..0x35 map to codes 1..5. The code is registered, and push_req is asserted in the next cycle.
  - 0x0D and 0x0A are ignored silently.
  - Any other byte increments bad_char_cnt, saturating at 255, and produces no push.
  - Bytes arriving while rx_data_valid is low are ignored.
- Frame tick:
  - vs_in is registered once (vs_q).
  - tick = (vs_in==VS_POL) && (vs_q!=VS_POL).
  - A vs_in held at the active level yields exactly one tick.
- Pop:
  - On a cycle with tick and fifo_level!=0 (level as registered before that cycle), the head entry is read.
  - cmd_code is loaded with it and cmd_valid=1 in the next cycle, for exactly one cycle.
  - cmd_code holds its value until the next pop.
  - A tick with an empty FIFO gives no strobe, and cmd_code is unchanged.
- Push:
  - On push_req, if fifo_level<FIFO_DEPTH the code is written at the tail.
  - Otherwise the code is dropped and overflow is set. overflow is cleared only by rst.
- Simultaneous push and pop in one cycle:
  - When not empty, both occur and fifo_level is unchanged.
  - When full, the pop frees a slot, so the push succeeds and overflow is not set.
  - When empty, no pop occurs; the pushed command waits for the next tick.
- Ordering: strict FIFO. Pointers wrap modulo FIFO_DEPTH. fifo_level never exceeds FIFO_DEPTH and never underflows.
- Latency: byte strobe to queued is 1 cycle. Output follows the first tick at least 1 cycle after enqueue, plus 1 cycle.
- No combinational path from any input to any output.

Test Plan:
- Reset mid-operation: queue 2 commands, assert rst for 1 cycle → fifo_level=0, cmd_code=0, overflow=0; the next tick gives no cmd_valid.
- Send 0x33, then one vs falling edge (VS_POL=0) → cmd_valid high for exactly 1 cycle with cmd_code=3; a second tick gives no strobe and cmd_code stays 3.
- Send '1','2','4','5' within one frame → fifo_level=4. Over 4 successive ticks the outputs are 1,2,4,5, one per frame. Holding vs_in low for many cycles yields only one strobe per tick.
- Send 6 valid bytes with no tick (depth 4) → fifo_level=4, overflow=1, and the last 2 are dropped. Subsequent ticks output the first 4 in order.
- Send 'A', 0x0D, 0x0A, '9', then 300 more 0x00 bytes → bad_char_cnt=2 after '9', then saturates at 255; fifo_level stays 0.
- FIFO full, with push_req coinciding with a tick → head is output, new code is enqueued, fifo_level stays 4, overflow stays 0.
- Empty FIFO, with push_req coinciding with a tick → no cmd_valid that frame; the code is output on the following tick.

Source files
------------

// File: rtl/uart_cmd_queue.sv
// UART key-byte decoder feeding a small command FIFO.
// Queued commands are released one per video frame, paced by the vsync edge.
module uart_cmd_queue #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic        VS_POL     = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_data_valid,
    input  logic                          vs_in,
    output logic [2:0]                    cmd_code,
    output logic                          cmd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [7:0]                    bad_char_cnt
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [2:0]    dec_code;
    logic          push_req;
    logic          vs_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [2:0]    mem [FIFO_DEPTH];

    logic is_cmd;
    logic is_eol;
    logic tick;
    logic pop;
    logic push_ok;

    // Byte classification: '1'..'5' are commands, CR/LF are silently skipped
    always_comb begin
        is_cmd = (rx_data >= 8'h31) && (rx_data <= 8'h35);
        is_eol = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    end

    // Pop uses the registered level, so a push in the same cycle cannot feed an empty pop
    always_comb begin
        tick    = (vs_in == VS_POL) && (vs_q != VS_POL);
        pop     = tick && (fifo_level != LW'(0));
        push_ok = push_req && ((fifo_level < LW'(FIFO_DEPTH)) || pop);
    end

    // Decode register and malformed-byte counter
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_code     <= 3'd0;
            push_req     <= 1'b0;
            bad_char_cnt <= 8'd0;
        end else begin
            push_req <= rx_data_valid && is_cmd;
            if (rx_data_valid && is_cmd) begin
                dec_code <= rx_data[2:0];
            end
            if (rx_data_valid && !is_cmd && !is_eol && (bad_char_cnt != 8'hFF)) begin
                bad_char_cnt <= bad_char_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q <= ~VS_POL;
        end else begin
            vs_q <= vs_in;
        end
    end

    // Storage array needs no reset; occupancy is tracked by the pointers and level
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= dec_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            cmd_code   <= 3'd0;
            cmd_valid  <= 1'b0;
        end else begin
            cmd_valid <= pop;
            if (pop) begin
                cmd_code <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_queue.sv
// Directed self-checking bench for uart_cmd_queue (FIFO_DEPTH=4, VS_POL=0).
module tb_uart_cmd_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       vs_in;
    logic [2:0] cmd_code;
    logic       cmd_valid;
    logic [2:0] fifo_level;
    logic       overflow;
    logic [7:0] bad_char_cnt;

    int n_total = 0;
    int n_bad   = 0;

    uart_cmd_queue #(.FIFO_DEPTH(4), .VS_POL(1'b0)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .vs_in         (vs_in),
        .cmd_code      (cmd_code),
        .cmd_valid     (cmd_valid),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .bad_char_cnt  (bad_char_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data       = b;
        rx_data_valid = 1'b1;
        step();
        rx_data_valid = 1'b0;
    endtask

    // Drive vs active for 'hold' cycles then inactive for one; count strobes seen
    task automatic do_tick(input int hold, output int nstrobe, output logic [2:0] code);
        nstrobe = 0;
        vs_in   = 1'b0;
        repeat (hold) begin
            step();
            if (cmd_valid === 1'b1) nstrobe++;
        end
        code  = cmd_code;
        vs_in = 1'b1;
        step();
        if (cmd_valid === 1'b1) nstrobe++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int         ns;
        logic [2:0] code;
        logic [2:0] exp4 [4];

        rst           = 1'b1;
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        vs_in         = 1'b1;
        step();
        step();
        rst = 1'b0;

        chk("rst_code",     32'(cmd_code),     32'd0);
        chk("rst_valid",    32'(cmd_valid),    32'd0);
        chk("rst_level",    32'(fifo_level),   32'd0);
        chk("rst_overflow", 32'(overflow),     32'd0);
        chk("rst_badcnt",   32'(bad_char_cnt), 32'd0);

        // Reset mid-queue discards everything
        send_byte(8'h31);
        send_byte(8'h32);
        step();
        chk("midrst_level_before", 32'(fifo_level), 32'd2);
        do_reset();
        chk("midrst_level", 32'(fifo_level), 32'd0);
        chk("midrst_code",  32'(cmd_code),   32'd0);
        chk("midrst_ovf",   32'(overflow),   32'd0);
        do_tick(2, ns, code);
        chk("midrst_tick_strobes", 32'(ns), 32'd0);

        // Single command through one frame
        send_byte(8'h33);
        step();
        chk("single_level", 32'(fifo_level), 32'd1);
        do_tick(2, ns, code);
        chk("single_strobes", 32'(ns),   32'd1);
        chk("single_code",    32'(code), 32'd3);
        chk("single_level_after", 32'(fifo_level), 32'd0);
        do_tick(2, ns, code);
        chk("empty_tick_strobes", 32'(ns),       32'd0);
        chk("empty_tick_code",    32'(cmd_code), 32'd3);

        // Four commands in one frame, long vs-active hold on the first
        send_byte(8'h31);
        send_byte(8'h32);
        send_byte(8'h34);
        send_byte(8'h35);
        step();
        chk("four_level", 32'(fifo_level), 32'd4);
        exp4[0] = 3'd1; exp4[1] = 3'd2; exp4[2] = 3'd4; exp4[3] = 3'd5;
        for (int i = 0; i < 4; i++) begin
            do_tick((i == 0) ? 40 : 3, ns, code);
            chk($sformatf("four_strobes_%0d", i), 32'(ns),   32'd1);
            chk($sformatf("four_code_%0d", i),    32'(code), 32'(exp4[i]));
        end
        chk("four_level_after", 32'(fifo_level), 32'd0);

        // Overflow: six commands, last two dropped
        send_byte(8'h31);
        send_byte(8'h32);
        send_byte(8'h33);
        send_byte(8'h34);
        send_byte(8'h35);
        send_byte(8'h31);
        step();
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_flag",  32'(overflow),   32'd1);
        for (int i = 0; i < 4; i++) begin
            do_tick(2, ns, code);
            chk($sformatf("ovf_code_%0d", i), 32'(code), 32'(i + 1));
        end
        do_tick(2, ns, code);
        chk("ovf_drained_strobes", 32'(ns),       32'd0);
        chk("ovf_sticky",          32'(overflow), 32'd1);
        do_reset();
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Malformed bytes and counter saturation
        send_byte(8'h41);
        chk("bad_after_A", 32'(bad_char_cnt), 32'd1);
        send_byte(8'h0D);
        send_byte(8'h0A);
        chk("bad_after_crlf", 32'(bad_char_cnt), 32'd1);
        send_byte(8'h39);
        chk("bad_after_9", 32'(bad_char_cnt), 32'd2);
        for (int i = 0; i < 251; i++) send_byte(8'h00);
        chk("bad_253", 32'(bad_char_cnt), 32'd253);
        for (int i = 0; i < 49; i++) send_byte(8'h00);
        step();
        chk("bad_saturated", 32'(bad_char_cnt), 32'd255);
        chk("bad_level",     32'(fifo_level),   32'd0);

        // Full FIFO: push coincides with a tick
        send_byte(8'h31);
        send_byte(8'h32);
        send_byte(8'h33);
        send_byte(8'h34);
        step();
        chk("full_level", 32'(fifo_level), 32'd4);
        send_byte(8'h35);
        vs_in = 1'b0;
        step();
        chk("full_pp_valid", 32'(cmd_valid),  32'd1);
        chk("full_pp_code",  32'(cmd_code),   32'd1);
        chk("full_pp_level", 32'(fifo_level), 32'd4);
        chk("full_pp_ovf",   32'(overflow),   32'd0);
        vs_in = 1'b1;
        step();
        exp4[0] = 3'd2; exp4[1] = 3'd3; exp4[2] = 3'd4; exp4[3] = 3'd5;
        for (int i = 0; i < 4; i++) begin
            do_tick(2, ns, code);
            chk($sformatf("full_drain_%0d", i), 32'(code), 32'(exp4[i]));
        end
        chk("full_drain_level", 32'(fifo_level), 32'd0);

        // Empty FIFO: push coincides with a tick, released one frame later
        send_byte(8'h32);
        vs_in = 1'b0;
        step();
        chk("empty_pp_valid", 32'(cmd_valid),  32'd0);
        chk("empty_pp_level", 32'(fifo_level), 32'd1);
        vs_in = 1'b1;
        step();
        do_tick(2, ns, code);
        chk("empty_pp_strobes", 32'(ns),   32'd1);
        chk("empty_pp_code",    32'(code), 32'd2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
